tart_vx_stream: RTL

//  Responder end of the visibilities read-back bus. Buffers completed blocks of

---
 rtl/tart_vx_stream.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tart_vx_stream.sv
// Visibilities read-back responder: block RAM ring of completed correlator blocks served a byte per bus transfer.
// Define TART_VX_CHECKSUM_EN to build the per-block wrap-around checksum; otherwise checksum is tied to zero.
module tart_vx_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACCUM = 24,
  parameter int unsigned BBITS = 4,
  parameter int unsigned LBITS = 5,
  parameter int unsigned DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  output logic             wat_o,
  output logic             rty_o,
  output logic             err_o,
  input  logic [BBITS-1:0] adr_i,
  output logic [WIDTH-1:0] dat_o,
  input  logic             wr_stb_i,
  input  logic [ACCUM-1:0] wr_dat_i,
  input  logic [ACCUM-1:0] blocksize,
  input  logic             enabled,
  input  logic             overwrite,
  output logic             newblock,
  output logic             streamed,
  output logic             overflow,
  output logic [ACCUM-1:0] checksum,
  output logic             stuck_o
);

  localparam int unsigned BYTES  = ACCUM / WIDTH;
  localparam int unsigned XBITS  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned ABITS  = BBITS + LBITS;
  localparam int unsigned DEPTH  = 2 ** ABITS;
  localparam int unsigned BS_MAX = (2 ** LBITS) - 1;

  logic [BBITS-1:0] wblk_q, wblk_d, rblk_q, rblk_d;
  logic [LBITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d, bs_q, bs_d;
  logic [XBITS-1:0] bidx_q, bidx_d;
  logic             en_q;
  logic             ack_d, rty_d, err_d, newblock_d, streamed_d, overflow_d, stuck_d;
  logic [WIDTH-1:0] dat_d;
  logic             accept, bad, empty, full, wen, wlast, blk_done;
  logic [ABITS-1:0] waddr, raddr;
  logic [ACCUM-1:0] rdata_q;
  logic [ACCUM-1:0] mem [DEPTH];
  logic             unused_delay;

  assign unused_delay = ^(32'(DELAY));
  assign wat_o        = 1'b0;

  // Next-state for both ring ends and the bus response
  always_comb begin
    wblk_d     = wblk_q;
    rblk_d     = rblk_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    bidx_d     = bidx_q;
    bs_d       = bs_q;
    ack_d      = 1'b0;
    rty_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = dat_o;
    newblock_d = 1'b0;
    streamed_d = 1'b0;
    overflow_d = overflow;
    stuck_d    = stuck_o;
    blk_done   = 1'b0;

    accept = cyc_i && stb_i && !ack_o && !rty_o && !err_o;
    bad    = we_i || (adr_i != rblk_q);
    empty  = (wblk_q == rblk_q);
    full   = ((wblk_q + BBITS'(1)) == rblk_q);
    wen    = enabled && wr_stb_i && !stuck_o && !rst_i;
    wlast  = (wptr_q == bs_q);

    if (!enabled)
      bs_d = (blocksize > ACCUM'(BS_MAX)) ? LBITS'(BS_MAX) : LBITS'(blocksize);

    if (accept) begin
      if (bad) begin
        err_d = 1'b1;
      end else if (empty) begin
        rty_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        dat_d = WIDTH'(rdata_q >> (WIDTH * (BYTES - 1 - 32'(bidx_q))));
        if (bidx_q == XBITS'(BYTES - 1)) begin
          bidx_d = '0;
          if (rptr_q == bs_q) begin
            rptr_d     = '0;
            rblk_d     = rblk_q + BBITS'(1);
            streamed_d = 1'b1;
            stuck_d    = 1'b0;
          end else begin
            rptr_d = rptr_q + LBITS'(1);
          end
        end else begin
          bidx_d = bidx_q + XBITS'(1);
        end
      end
    end

    if (enabled && !en_q)
      overflow_d = 1'b0;

    // A reader finishing a block in the same cycle frees the slot, so that completion is not an overflow
    if (!enabled) begin
      wptr_d = '0;
    end else if (wen) begin
      if (!wlast) begin
        wptr_d = wptr_q + LBITS'(1);
      end else begin
        wptr_d = '0;
        if (full && !streamed_d) begin
          overflow_d = 1'b1;
          if (overwrite) begin
            wblk_d   = wblk_q + BBITS'(1);
            rblk_d   = rblk_q + BBITS'(1);
            rptr_d   = '0;
            bidx_d   = '0;
            blk_done = 1'b1;
          end else begin
            stuck_d = 1'b1;
          end
        end else begin
          wblk_d   = wblk_q + BBITS'(1);
          blk_done = 1'b1;
        end
      end
    end
    newblock_d = blk_done;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wblk_q   <= '0;
      rblk_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      bidx_q   <= '0;
      bs_q     <= '0;
      en_q     <= 1'b0;
      ack_o    <= 1'b0;
      rty_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      newblock <= 1'b0;
      streamed <= 1'b0;
      overflow <= 1'b0;
      stuck_o  <= 1'b0;
    end else begin
      wblk_q   <= wblk_d;
      rblk_q   <= rblk_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      bidx_q   <= bidx_d;
      bs_q     <= bs_d;
      en_q     <= enabled;
      ack_o    <= ack_d;
      rty_o    <= rty_d;
      err_o    <= err_d;
      dat_o    <= dat_d;
      newblock <= newblock_d;
      streamed <= streamed_d;
      overflow <= overflow_d;
      stuck_o  <= stuck_d;
    end
  end

  // Read port tracks next-cycle pointers with write bypass, so rdata_q always holds the current read word
  assign waddr = {wblk_q, wptr_q};
  assign raddr = rst_i ? '0 : {rblk_d, rptr_d};

  always_ff @(posedge clk_i) begin
    if (wen)
      mem[waddr] <= wr_dat_i;
    rdata_q <= (wen && (waddr == raddr)) ? wr_dat_i : mem[raddr];
  end

`ifdef TART_VX_CHECKSUM_EN
  logic [ACCUM-1:0] run_q, chk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= '0;
      chk_q <= '0;
    end else begin
      if (!enabled)
        run_q <= '0;
      else if (wen)
        run_q <= wlast ? '0 : (run_q + wr_dat_i);
      if (blk_done)
        chk_q <= run_q + wr_dat_i;
    end
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule
